// File: rtl/vector_lane_serializer_pkg.sv
// Shared types and constants for the vector-to-scalar store path.
// Imported by the serializer and by the reduce_step datapath.
package vec_pkg;

    localparam int LANES = 6;

    typedef enum logic [1:0] {
        VS_STORE = 2'b00,
        VS_SUM   = 2'b01,
        VS_MAX   = 2'b10
    } vsm_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        ACC,
        WRITE
    } vs_state_t;

endpackage

// File: rtl/vector_lane_serializer_reduce_step.sv
// One step of a lane reduction: fold a single lane into the accumulator.
// Kept standalone so the vector-reduce ALU op can share it.
module reduce_step
    import vec_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] lane,
    input  logic         en,
    input  vsm_mode_t    mode,
    output logic [N-1:0] next_acc
);

    always_comb begin
        next_acc = acc;
        if (en) begin
            case (mode)
                VS_SUM:  next_acc = acc + lane;
                VS_MAX:  next_acc = (lane > acc) ? lane : acc;
                default: next_acc = acc;
            endcase
        end
    end

endmodule

// File: rtl/vector_lane_serializer.sv
// Drains a multi-lane vector result into a byte-wide memory write port,
// either lane by lane or as a single sum/max reduction.
module vector_lane_serializer
    import vec_pkg::*;
#(
    parameter int N     = 8,
    parameter int LANES = vec_pkg::LANES,
    parameter int AW    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      InValidM,
    output logic                      InReadyM,
    input  logic [LANES-1:0][N-1:0]   VecDataM,
    input  logic [LANES-1:0]          LaneMaskM,
    input  logic [AW-1:0]             BaseAddrM,
    input  logic [1:0]                ModeM,
    output logic                      MemWE,
    output logic [AW-1:0]             MemAddr,
    output logic [N-1:0]              MemWD,
    input  logic                      MemReady,
    output logic                      Busy,
    output logic                      Done,
    output logic [N-1:0]              RedResult
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    vs_state_t              r_state;
    vsm_mode_t              r_mode;
    logic [LANES-1:0][N-1:0] r_data;
    logic [LANES-1:0]       r_mask;
    logic [AW-1:0]          r_base;
    logic [IW-1:0]          r_idx;
    logic [N-1:0]           r_acc;
    logic                   r_we;
    logic [AW-1:0]          r_addr;
    logic [N-1:0]           r_wd;
    logic                   r_done;
    logic [N-1:0]           r_red;

    vsm_mode_t              w_in_mode;
    logic [IW-1:0]          w_nidx;
    logic                   w_last;
    logic [N-1:0]           w_next_acc;

    // Reserved mode encoding falls back to a plain lane store.
    always_comb begin
        case (ModeM)
            2'b01:   w_in_mode = VS_SUM;
            2'b10:   w_in_mode = VS_MAX;
            default: w_in_mode = VS_STORE;
        endcase
    end

    assign w_nidx = r_idx + IW'(1);
    assign w_last = (r_idx == IW'(LANES - 1));

    reduce_step #(.N(N)) u_reduce_step (
        .acc      (r_acc),
        .lane     (r_data[r_idx]),
        .en       (r_mask[r_idx]),
        .mode     (r_mode),
        .next_acc (w_next_acc)
    );

    // Write port outputs are registered one edge ahead of the lane they carry,
    // so every transition also preloads the next lane's address and data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= VS_STORE;
            r_data  <= '0;
            r_mask  <= '0;
            r_base  <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wd    <= '0;
            r_done  <= 1'b0;
            r_red   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (InValidM) begin
                        r_data <= VecDataM;
                        r_mask <= LaneMaskM;
                        r_base <= BaseAddrM;
                        r_mode <= w_in_mode;
                        r_idx  <= '0;
                        r_acc  <= '0;
                        if (w_in_mode == VS_STORE) begin
                            r_state <= SEND;
                            r_we    <= LaneMaskM[0];
                            r_addr  <= BaseAddrM;
                            r_wd    <= VecDataM[0];
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                SEND: begin
                    // Masked lanes still burn a cycle so address offset == lane index.
                    if (!r_we || MemReady) begin
                        if (w_last) begin
                            r_state <= IDLE;
                            r_we    <= 1'b0;
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_idx  <= w_nidx;
                            r_we   <= r_mask[w_nidx];
                            r_addr <= r_base + AW'(w_nidx);
                            r_wd   <= r_data[w_nidx];
                        end
                    end
                end
                ACC: begin
                    r_acc <= w_next_acc;
                    if (w_last) begin
                        r_state <= WRITE;
                        r_idx   <= '0;
                        r_we    <= 1'b1;
                        r_addr  <= r_base;
                        r_wd    <= w_next_acc;
                    end else begin
                        r_idx <= w_nidx;
                    end
                end
                WRITE: begin
                    if (MemReady) begin
                        r_state <= IDLE;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_red   <= r_acc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign InReadyM  = (r_state == IDLE);
    assign Busy      = (r_state != IDLE);
    assign MemWE     = r_we;
    assign MemAddr   = r_addr;
    assign MemWD     = r_wd;
    assign Done      = r_done;
    assign RedResult = r_red;

endmodule

// File: tb/tb_vector_lane_serializer.sv
// Directed, table-driven bench for vector_lane_serializer with hand-computed
// expectations plus stall and mid-operation reset sequences.
module tb_vector_lane_serializer;

    logic              clk;
    logic              reset;
    logic              InValidM;
    logic              InReadyM;
    logic [5:0][7:0]   VecDataM;
    logic [5:0]        LaneMaskM;
    logic [15:0]       BaseAddrM;
    logic [1:0]        ModeM;
    logic              MemWE;
    logic [15:0]       MemAddr;
    logic [7:0]        MemWD;
    logic              MemReady;
    logic              Busy;
    logic              Done;
    logic [7:0]        RedResult;

    int total;
    int bad;

    vector_lane_serializer #(.N(8), .LANES(6), .AW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .InValidM  (InValidM),
        .InReadyM  (InReadyM),
        .VecDataM  (VecDataM),
        .LaneMaskM (LaneMaskM),
        .BaseAddrM (BaseAddrM),
        .ModeM     (ModeM),
        .MemWE     (MemWE),
        .MemAddr   (MemAddr),
        .MemWD     (MemWD),
        .MemReady  (MemReady),
        .Busy      (Busy),
        .Done      (Done),
        .RedResult (RedResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        mode;
        logic [5:0]        mask;
        logic [15:0]       base;
        logic [5:0][7:0]   d;
        int                nw;
        logic [5:0][15:0]  ea;
        logic [5:0][7:0]   ed;
        int                lat;
        logic [7:0]        ered;
    } vec_t;

    localparam int NV = 9;
    vec_t tv [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] mode, input logic [5:0] mask,
                             input logic [15:0] base, input logic [5:0][7:0] d);
        InValidM  = 1'b1;
        ModeM     = mode;
        LaneMaskM = mask;
        BaseAddrM = base;
        VecDataM  = d;
    endtask

    // Called at #1 after a rising edge with the DUT idle.
    task automatic run_vec(input int k);
        vec_t v;
        int   cyc;
        int   nw;
        v   = tv[k];
        cyc = 0;
        nw  = 0;
        chk("accept_ready", 32'(InReadyM), 32'd1);
        drive_req(v.mode, v.mask, v.base, v.d);
        @(posedge clk); #1;
        InValidM = 1'b0;
        while (!Done && cyc < 40) begin
            if (MemWE && MemReady) begin
                if (nw < 6 && nw < v.nw) begin
                    chk("wr_addr", 32'(MemAddr), 32'(v.ea[nw]));
                    chk("wr_data", 32'(MemWD), 32'(v.ed[nw]));
                end else begin
                    chk("extra_write", 32'(nw), 32'(v.nw - 1));
                end
                nw++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("write_count", 32'(nw), 32'(v.nw));
        chk("latency", 32'(cyc), 32'(v.lat));
        chk("red_result", 32'(RedResult), 32'(v.ered));
        $display("txn %0d mode=%b mask=%b base=%h writes=%0d latency=%0d red=%h",
                 k, v.mode, v.mask, v.base, nw, cyc, RedResult);
    endtask

    initial begin
        int cyc;
        int nw;
        total = 0;
        bad   = 0;

        // Expected writes are listed with element [0] as the rightmost entry.
        tv[0] = '{mode:2'b00, mask:6'b111111, base:16'h0010,
                  d:{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, nw:6,
                  ea:{16'h0015, 16'h0014, 16'h0013, 16'h0012, 16'h0011, 16'h0010},
                  ed:{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, lat:6, ered:8'h00};
        tv[1] = '{mode:2'b00, mask:6'b100101, base:16'hFFFE,
                  d:{8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0}, nw:3,
                  ea:{48'h0, 16'h0003, 16'h0000, 16'hFFFE},
                  ed:{24'h0, 8'hA5, 8'hA2, 8'hA0}, lat:6, ered:8'h00};
        tv[2] = '{mode:2'b01, mask:6'b111111, base:16'h0020,
                  d:{6{8'h80}}, nw:1,
                  ea:{80'h0, 16'h0020}, ed:{40'h0, 8'h00}, lat:7, ered:8'h00};
        tv[3] = '{mode:2'b10, mask:6'b101111, base:16'h0040,
                  d:{8'h01, 8'hFF, 8'h7F, 8'h03, 8'hF0, 8'h05}, nw:1,
                  ea:{80'h0, 16'h0040}, ed:{40'h0, 8'hF0}, lat:7, ered:8'hF0};
        tv[4] = '{mode:2'b01, mask:6'b000101, base:16'h1234,
                  d:{8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10}, nw:1,
                  ea:{80'h0, 16'h1234}, ed:{40'h0, 8'h40}, lat:7, ered:8'h40};
        tv[5] = '{mode:2'b01, mask:6'b000000, base:16'h0050,
                  d:{8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, nw:1,
                  ea:{80'h0, 16'h0050}, ed:{40'h0, 8'h00}, lat:7, ered:8'h00};
        tv[6] = '{mode:2'b00, mask:6'b000000, base:16'h0060,
                  d:{8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, nw:0,
                  ea:'0, ed:'0, lat:6, ered:8'h00};
        tv[7] = '{mode:2'b10, mask:6'b111111, base:16'h0070,
                  d:{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, nw:1,
                  ea:{80'h0, 16'h0070}, ed:{40'h0, 8'h06}, lat:7, ered:8'h06};
        tv[8] = '{mode:2'b11, mask:6'b000011, base:16'h0100,
                  d:{8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, nw:2,
                  ea:{64'h0, 16'h0101, 16'h0100},
                  ed:{32'h0, 8'h22, 8'h11}, lat:6, ered:8'h06};

        reset     = 1'b1;
        InValidM  = 1'b0;
        VecDataM  = '0;
        LaneMaskM = '0;
        BaseAddrM = '0;
        ModeM     = 2'b00;
        MemReady  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_ready", 32'(InReadyM), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_we", 32'(MemWE), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_addr", 32'(MemAddr), 32'd0);
        chk("rst_wd", 32'(MemWD), 32'd0);
        chk("rst_red", 32'(RedResult), 32'd0);

        for (int k = 0; k < NV; k++) run_vec(k);

        // Memory stalls three cycles on lane 0; outputs must hold.
        MemReady = 1'b0;
        drive_req(2'b00, 6'b111111, 16'h0200, {8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31});
        @(posedge clk); #1;
        InValidM = 1'b0;
        cyc = 0;
        nw  = 0;
        while (!Done && cyc < 40) begin
            if (cyc == 3) MemReady = 1'b1;
            if (cyc <= 3)
                chk("stall_hold", {7'd0, MemWE, MemAddr, MemWD}, {7'd0, 1'b1, 16'h0200, 8'h31});
            chk("stall_ready_low", 32'(InReadyM), 32'd0);
            if (MemWE && MemReady) nw++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall_latency", 32'(cyc), 32'd9);
        chk("stall_writes", 32'(nw), 32'd6);
        $display("txn stall writes=%0d latency=%0d", nw, cyc);

        // Reset during SEND at lane 2 aborts without a Done pulse.
        drive_req(2'b00, 6'b111111, 16'h0300, {8'h46, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41});
        @(posedge clk); #1;
        InValidM = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_addr", 32'(MemAddr), 32'h0302);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_we", 32'(MemWE), 32'd0);
        chk("abort_ready", 32'(InReadyM), 32'd1);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_red", 32'(RedResult), 32'd0);
        nw = 0;
        for (int i = 0; i < 8; i++) begin
            if (Done || MemWE) nw++;
            @(posedge clk); #1;
        end
        chk("abort_quiet", 32'(nw), 32'd0);
        $display("txn reset_abort stray_events=%0d", nw);

        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_lane_serializer.md
Name: vector_lane_serializer

Overview:
- Drains the 6-lane vector result produced by the execute-stage lane ALUs into the scalar, byte-wide data-memory write port. It is the vector-to-scalar direction, the inverse of scalar-to-lane broadcast.
- Stores one lane per cycle to consecutive addresses, or reduces the enabled lanes (sum or unsigned max) to one scalar and stores that.
- Sits between the memory-stage vector store path and the data memory. The pipeline stalls on busy.

Parameters:
- N, 8, lane data width in bits
- LANES, 6, number of vector lanes
- AW, 16, memory address width

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- InValidM  input  1  a vector store request is presented
- InReadyM  output  1  serializer can accept a request this cycle
- VecDataM  input  [LANES-1:0][N-1:0]  lane data; lane 0 is the lowest index
- LaneMaskM  input  LANES  per-lane enable; bit i enables lane i
- BaseAddrM  input  AW  base address
- ModeM  input  2  00 store lanes, 01 reduce-sum, 10 reduce-max (unsigned), 11 reserved and treated as 00
- MemWE  output  1  memory write strobe
- MemAddr  output  AW  write address
- MemWD  output  N  write data
- MemReady  input  1  memory accepts the write this cycle
- Busy  output  1  request in progress
- Done  output  1  one-cycle pulse when a request completes
- RedResult  output  N  last reduction value, held until the next reduction completes

Behaviour:
- Reset values (next edge, any state): state IDLE; MemWE, Done, Busy all 0; MemAddr, MemWD, RedResult all 0; lane index 0; accumulator 0. InReadyM is 1 after reset.
- Reset mid-operation aborts the request immediately. No further write is issued and Done does not pulse.
- Accept: in IDLE, InReadyM=1. When InValidM=1 on that edge, latch VecDataM, LaneMaskM, BaseAddrM and ModeM; set idx=0 and acc=0. Go to SEND for store mode, or to ACC for a reduce mode. Inputs are ignored outside IDLE.
- Busy=1 in SEND, ACC and WRITE. InReadyM = (state==IDLE).
- SEND, one lane per cycle:
  - Enabled lane: drive MemWE=1, MemAddr=BaseAddr+idx (wraps mod 2^AW), MemWD=lane[idx].
  - Hold these outputs stable until the cycle MemReady=1, then advance idx.
  - Masked lane: MemWE=0 and advance idx unconditionally. Masked lanes still occupy a cycle, so the address offset always equals the lane index.
  - After lane LANES-1 advances, go to IDLE and pulse Done.
- ACC, one lane per cycle, no memory traffic, exactly LANES cycles:
  - Sum mode: if mask[idx], acc = acc + lane[idx], truncated to N bits (wraps).
  - Max mode: if mask[idx], acc = max(acc, lane[idx]), unsigned compare.
  - Then go to WRITE.
- WRITE: drive MemWE=1, MemAddr=BaseAddr, MemWD=acc until MemReady=1. On that edge, set RedResult=acc, go to IDLE and pulse Done.
- Done is high during the first IDLE cycle after completion. A new request may be accepted in that same cycle.
- Latency: store with MemReady held at 1 takes LANES cycles from accept to Done. Reduce with MemReady held at 1 takes LANES+1 cycles.
- All-zero mask:
  - Store: walks all lanes with no writes, then Done.
  - Reduce: writes 0 to BaseAddr.
- MemReady is ignored when MemWE=0. It may stay low indefinitely, and the block simply holds its write outputs stable.

Decomposition:
- Shared package vec_pkg contains:
  - constant LANES=6
  - enum vsm_mode_t {VS_STORE, VS_SUM, VS_MAX}
  - enum vs_state_t {IDLE, SEND, ACC, WRITE}
- One combinational sub-module, reduce_step, with inputs (acc, lane, en, mode) and output next_acc. It is reused later by a vector-reduce ALU op.

Test Plan:
- Store, mask 6'b111111, base 0x0010, lanes 1..6, MemReady=1 -> writes (0x10,1) through (0x15,6) on consecutive cycles; Done 6 cycles after accept.
- Store, mask 6'b100101, base 0xFFFE, lanes 0xA0..0xA5 -> writes (0xFFFE,A0), (0x0000,A2), (0x0003,A5); address wraps; no write on masked cycles; Done after 6 cycles.
- Sum, all lanes 0x80, mask all ones, base 0x20 -> single write (0x20,0x00); acc wraps mod 256; RedResult=0x00.
- Max, lanes {5,0xF0,3,0x7F,0xFF,1}, mask 6'b101111 (lane 4 masked) -> write value 0xF0; RedResult=0xF0.
- Store with MemReady low for 3 cycles on lane 0 -> MemWE, MemAddr and MemWD held stable for 4 cycles; total latency 9 cycles; InReadyM=0 throughout.
- Reset asserted during SEND at lane 2 -> MemWE=0 from the next cycle; no Done pulse; InReadyM=1; a following request behaves normally from idx 0.
